// File: rtl/tlc_controller_param.sv
// rtl/tlc_controller_param.sv - highway/farm intersection controller with pre-emption and night flash
module tlc_controller_param #(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int CNT_W         = 32,
    parameter int HG_MIN_S      = 30,
    parameter int HY_S          = 3,
    parameter int AR_S          = 1,
    parameter int FG_MIN_S      = 5,
    parameter int FG_MAX_S      = 15,
    parameter int FY_S          = 3,
    parameter int FLASH_HALF_S  = 1
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       farmSensor,
    input  logic       emergency,
    input  logic       flashMode,
    output logic [1:0] highwaySignal,
    output logic [1:0] farmSignal,
    output logic [2:0] state,
    output logic       RstCount
);

    localparam logic [2:0] HWY_GREEN   = 3'd0;
    localparam logic [2:0] HWY_YELLOW  = 3'd1;
    localparam logic [2:0] ALL_RED_F   = 3'd2;
    localparam logic [2:0] FARM_GREEN  = 3'd3;
    localparam logic [2:0] FARM_YELLOW = 3'd4;
    localparam logic [2:0] ALL_RED_H   = 3'd5;
    localparam logic [2:0] PREEMPT     = 3'd6;
    localparam logic [2:0] FLASH       = 3'd7;

    localparam logic [1:0] SIG_OFF    = 2'b00;
    localparam logic [1:0] SIG_GREEN  = 2'b01;
    localparam logic [1:0] SIG_YELLOW = 2'b10;
    localparam logic [1:0] SIG_RED    = 2'b11;

    // Durations are held as "last count value" (D-1); products done in 64 bits to avoid int overflow.
    localparam longint TPS = longint'(TICKS_PER_SEC);
    localparam logic [CNT_W-1:0] HG_LAST = CNT_W'(longint'(HG_MIN_S) * TPS - 1);
    localparam logic [CNT_W-1:0] HY_LAST = CNT_W'(longint'(HY_S) * TPS - 1);
    localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(longint'(AR_S) * TPS - 1);
    localparam logic [CNT_W-1:0] FGN_LAST = CNT_W'(longint'(FG_MIN_S) * TPS - 1);
    localparam logic [CNT_W-1:0] FGX_LAST = CNT_W'(longint'(FG_MAX_S) * TPS - 1);
    localparam logic [CNT_W-1:0] FY_LAST = CNT_W'(longint'(FY_S) * TPS - 1);
    localparam logic [CNT_W-1:0] FH_LAST = CNT_W'(longint'(FLASH_HALF_S) * TPS - 1);

    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic             farmSync;
    logic             emergSync;
    logic             flashSync;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] flashCnt;
    logic             flashPhase;
    logic             farmReq;
    logic [2:0]       nextState;

    assign farmSync  = sync2[2];
    assign emergSync = sync2[1];
    assign flashSync = sync2[0];

    always_comb begin
        nextState = state;
        case (state)
            HWY_GREEN: begin
                if (emergSync || flashSync || (count >= HG_LAST && farmReq))
                    nextState = HWY_YELLOW;
            end
            HWY_YELLOW: begin
                if (count == HY_LAST) nextState = ALL_RED_F;
            end
            ALL_RED_F: begin
                if (count == AR_LAST) begin
                    if (emergSync)      nextState = PREEMPT;
                    else if (flashSync) nextState = FLASH;
                    else                nextState = FARM_GREEN;
                end
            end
            FARM_GREEN: begin
                if (emergSync || flashSync || (count >= FGN_LAST && !farmSync) ||
                    count == FGX_LAST)
                    nextState = FARM_YELLOW;
            end
            FARM_YELLOW: begin
                if (count == FY_LAST) nextState = ALL_RED_H;
            end
            ALL_RED_H: begin
                if (count == AR_LAST) begin
                    if (emergSync)      nextState = PREEMPT;
                    else if (flashSync) nextState = FLASH;
                    else                nextState = HWY_GREEN;
                end
            end
            PREEMPT: begin
                if (!emergSync) nextState = ALL_RED_H;
            end
            FLASH: begin
                if (emergSync)       nextState = PREEMPT;
                else if (!flashSync) nextState = ALL_RED_H;
            end
            default: nextState = ALL_RED_H;
        endcase
    end

    assign RstCount = Rst || (nextState != state);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync1      <= '0;
            sync2      <= '0;
            state      <= ALL_RED_H;
            count      <= '0;
            flashCnt   <= '0;
            flashPhase <= 1'b0;
            farmReq    <= 1'b0;
        end else begin
            sync1 <= {farmSensor, emergency, flashMode};
            sync2 <= sync1;
            state <= nextState;

            if (RstCount)
                count <= '0;
            else if (count != '1)
                count <= count + CNT_W'(1);

            // Request is consumed by entering farm green; anything seen later re-arms it.
            if (state != FARM_GREEN && nextState == FARM_GREEN)
                farmReq <= 1'b0;
            else if (farmSync && state != FARM_GREEN)
                farmReq <= 1'b1;

            if (state == FLASH && nextState == FLASH) begin
                if (flashCnt == FH_LAST) begin
                    flashCnt   <= '0;
                    flashPhase <= ~flashPhase;
                end else begin
                    flashCnt <= flashCnt + CNT_W'(1);
                end
            end else begin
                flashCnt   <= '0;
                flashPhase <= 1'b0;
            end
        end
    end

    always_comb begin
        highwaySignal = SIG_RED;
        farmSignal    = SIG_RED;
        case (state)
            HWY_GREEN:   highwaySignal = SIG_GREEN;
            HWY_YELLOW:  highwaySignal = SIG_YELLOW;
            FARM_GREEN:  farmSignal    = SIG_GREEN;
            FARM_YELLOW: farmSignal    = SIG_YELLOW;
            FLASH: begin
                highwaySignal = flashPhase ? SIG_OFF : SIG_YELLOW;
                farmSignal    = flashPhase ? SIG_OFF : SIG_RED;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tlc_controller_param.sv
// tb/tb_tlc_controller_param.sv - directed self-checking bench for tlc_controller_param
module tb_tlc_controller_param;

    logic       Clk;
    logic       Rst;
    logic       farmSensor;
    logic       emergency;
    logic       flashMode;
    logic [1:0] highwaySignal;
    logic [1:0] farmSignal;
    logic [2:0] state;
    logic       RstCount;

    int errors = 0;
    int checks = 0;

    tlc_controller_param #(
        .TICKS_PER_SEC(1),
        .CNT_W        (8),
        .HG_MIN_S     (10),
        .HY_S         (3),
        .AR_S         (2),
        .FG_MIN_S     (4),
        .FG_MAX_S     (8),
        .FY_S         (3),
        .FLASH_HALF_S (2)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .farmSensor   (farmSensor),
        .emergency    (emergency),
        .flashMode    (flashMode),
        .highwaySignal(highwaySignal),
        .farmSignal   (farmSignal),
        .state        (state),
        .RstCount     (RstCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Counts cycles the given state persists, starting from its first cycle.
    task automatic measure(input logic [2:0] s, output int n);
        n = 0;
        while (state === s && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_state(input logic [2:0] s);
        int n;
        n = 0;
        while (state !== s && n < 100) begin
            n++;
            tick();
        end
        chk("wait_state", state, s);
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        tick();
        tick();
        Rst = 1'b0;
        tick();
        tick();
        chk("reset_to_hg", state, 0);
    endtask

    initial begin
        int n;
        logic bad;

        Rst = 1'b1;
        farmSensor = 1'b0;
        emergency = 1'b0;
        flashMode = 1'b0;
        tick(); tick(); tick();
        chk("rst_state", state, 5);
        chk("rst_hwy", highwaySignal, 2'b11);
        chk("rst_farm", farmSignal, 2'b11);
        chk("rst_rstcount", RstCount, 1);
        Rst = 1'b0;
        chk("rel0_state", state, 5);
        tick();
        chk("rel1_state", state, 5);
        chk("rel1_hwy", highwaySignal, 2'b11);
        tick();
        chk("hg_state", state, 0);
        chk("hg_hwy", highwaySignal, 2'b01);
        chk("hg_farm", farmSignal, 2'b11);

        bad = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (state !== 3'd0 || RstCount !== 1'b0) bad = 1'b1;
            tick();
        end
        chk("idle_hold", bad, 0);
        chk("count_sat", dut.count, 8'hFF);

        // Single-cycle sensor pulse at highway-green cycle 3
        do_reset();
        tick(); tick(); tick();
        farmSensor = 1'b1;
        tick();
        farmSensor = 1'b0;
        measure(0, n); chk("pulse_hg_dwell", n + 4, 10);
        measure(1, n); chk("pulse_hy_dwell", n, 3);
        measure(2, n); chk("pulse_arf_dwell", n, 2);
        chk("pulse_fg_farm", farmSignal, 2'b01);
        chk("pulse_fg_hwy", highwaySignal, 2'b11);
        measure(3, n); chk("pulse_fg_dwell", n, 4);
        chk("pulse_fy_farm", farmSignal, 2'b10);
        measure(4, n); chk("pulse_fy_dwell", n, 3);
        measure(5, n); chk("pulse_arh_dwell", n, 2);
        chk("pulse_back_hg", state, 0);

        // Sensor held high: farm green runs to its maximum, request re-latches
        farmSensor = 1'b1;
        measure(0, n); chk("held_hg_dwell", n, 10);
        measure(1, n); chk("held_hy_dwell", n, 3);
        measure(2, n); chk("held_arf_dwell", n, 2);
        measure(3, n); chk("held_fg_max", n, 8);
        measure(4, n); chk("held_fy_dwell", n, 3);
        measure(5, n); chk("held_arh_dwell", n, 2);
        measure(0, n); chk("held_hg2_dwell", n, 10);
        farmSensor = 1'b0;

        // Emergency during farm green
        do_reset();
        farmSensor = 1'b1;
        tick();
        farmSensor = 1'b0;
        wait_state(3);
        tick();
        emergency = 1'b1;
        tick(); chk("emg_fg_c2", state, 3);
        tick(); chk("emg_fg_c3", state, 3);
        tick(); chk("emg_fy_start", state, 4);
        measure(4, n); chk("emg_fy_dwell", n, 3);
        measure(5, n); chk("emg_arh_dwell", n, 2);
        chk("emg_preempt", state, 6);
        chk("emg_pre_hwy", highwaySignal, 2'b11);
        chk("emg_pre_farm", farmSignal, 2'b11);
        repeat (5) tick();
        chk("emg_pre_hold", state, 6);
        emergency = 1'b0;
        tick(); chk("emg_rel1", state, 6);
        tick(); chk("emg_rel2", state, 6);
        tick(); chk("emg_rel_arh", state, 5);
        measure(5, n); chk("emg_rel_arh_dwell", n, 2);
        chk("emg_rel_hg", state, 0);

        // Night flash entered from highway green
        flashMode = 1'b1;
        tick(); chk("fl_sync1", state, 0);
        tick(); chk("fl_sync2", state, 0);
        tick(); chk("fl_hy", state, 1);
        measure(1, n); chk("fl_hy_dwell", n, 3);
        measure(2, n); chk("fl_arf_dwell", n, 2);
        chk("fl_state", state, 7);
        chk("fl_c0_hwy", highwaySignal, 2'b10);
        chk("fl_c0_farm", farmSignal, 2'b11);
        tick(); chk("fl_c1_hwy", highwaySignal, 2'b10);
        tick(); chk("fl_c2_hwy", highwaySignal, 2'b00);
        chk("fl_c2_farm", farmSignal, 2'b00);
        tick(); chk("fl_c3_hwy", highwaySignal, 2'b00);
        tick(); chk("fl_c4_hwy", highwaySignal, 2'b10);
        chk("fl_c4_farm", farmSignal, 2'b11);
        emergency = 1'b1;
        tick(); chk("fl_emg1", state, 7);
        tick(); chk("fl_emg2", state, 7);
        tick(); chk("fl_emg_pre", state, 6);
        emergency = 1'b0;
        tick(); tick(); tick();
        chk("fl_rel_arh", state, 5);
        measure(5, n); chk("fl_rel_arh_dwell", n, 2);
        chk("fl_reenter", state, 7);
        Rst = 1'b1;
        tick();
        chk("fl_rst_state", state, 5);
        chk("fl_rst_hwy", highwaySignal, 2'b11);
        chk("fl_rst_farm", farmSignal, 2'b11);
        Rst = 1'b0;
        flashMode = 1'b0;
        tick(); tick();
        chk("fl_rst_hg", state, 0);

        // Emergency and flash together: emergency wins
        emergency = 1'b1;
        flashMode = 1'b1;
        tick(); tick(); tick();
        chk("both_hy", state, 1);
        measure(1, n); chk("both_hy_dwell", n, 3);
        measure(2, n); chk("both_arf_dwell", n, 2);
        chk("both_preempt", state, 6);
        emergency = 1'b0;
        flashMode = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
